jtdd_mcu_arb: RTL and testbench
===============================

JTDD_MCU_ARB -- requirements
Module: jtdd_mcu_arb

Interface
REQ-001 Parameter TOUT, default 8'd200: cen6 ticks to wait for mcu_halted before abandoning a halt request.
REQ-002 Parameter GAP, default 3'd4: minimum cen6 ticks the MCU SHALL run between two consecutive halts.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rstb  in  1  asynchronous, active-low reset.
REQ-005 cen6  in  1  clock enable; timing counters advance only when high.
REQ-006 main_req  in  1  level; main CPU requests the shared RAM (com_cs decode).
REQ-007 nmi_req  in  1  single-cycle pulse; main CPU command to interrupt the MCU.
REQ-008 main_ack  out  1  shared RAM granted to the main CPU.
REQ-009 mcu_halt  out  1  halt request to the MCU.
REQ-010 mcu_halted  in  1  MCU halt acknowledge.
REQ-011 mcu_nmi_set  out  1  single-cycle NMI pulse to the MCU.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 tout_err  out  1  sticky flag: a halt request timed out.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, HALT, GRANT, REL, NMI.
REQ-015 IDLE->HALT when main_req=1 and gap counter is 0; mcu_halt SHALL be asserted on that same edge.
REQ-016 HALT->GRANT on the first clk edge with mcu_halted=1; main_ack SHALL rise on that edge, one cycle after halted is seen.
REQ-017 HALT->REL when the timeout counter reaches TOUT; this SHALL set tout_err, and main_ack SHALL stay 0.
REQ-018 Timeout counter: 8-bit; cleared on entry to HALT; increments once per cen6 tick while in HALT; SHALL NOT wrap.
REQ-019 GRANT is held while main_req=1; on main_req=0, main_ack SHALL fall and the FSM SHALL go to REL on that same edge.
REQ-020 REL: mcu_halt=0; the FSM waits for mcu_halted=0, then loads the gap counter with GAP and goes to NMI if an NMI is pending, else to IDLE.
REQ-021 Gap counter: decrements once per cen6 tick down to 0; while it is nonzero, IDLE SHALL NOT leave for HALT.
REQ-022 An nmi_req arriving in any state SHALL set a one-deep pending flag; further pulses while it is set SHALL be absorbed.
REQ-023 In IDLE, a pending NMI SHALL take priority over main_req: the FSM goes to NMI.
REQ-024 NMI: mcu_nmi_set SHALL be high for exactly one clk cycle, the pending flag SHALL clear, and the FSM returns to IDLE next cycle.
REQ-025 nmi_req on the same edge the pending flag clears SHALL re-set the flag; the pulse is not lost.
REQ-026 mcu_halted rising while in IDLE or NMI SHALL be ignored.
REQ-027 main_ack=1 SHALL imply mcu_halt=1 and mcu_halted=1 on the same cycle.

Reset
REQ-028 With rstb=0, asynchronously: state=IDLE, main_ack=0, mcu_halt=0, mcu_nmi_set=0, busy=0, tout_err=0, pending NMI=0, both counters=0.
REQ-029 Reset asserted mid-grant SHALL drop main_ack and mcu_halt immediately; no NMI is issued after reset release.

Configuration
REQ-030 Macro JTDD_MCUARB_STATS_EN defined: adds outputs grant_cnt[15:0] (grants) and tout_cnt[7:0] (timeouts), both saturating, both reset to 0.
REQ-031 Macro JTDD_MCUARB_STATS_EN absent: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package jtdd_mcu_pkg SHALL hold the state encoding (3-bit) and the default TOUT/GAP constants.
REQ-033 The timeout and gap counting SHALL live in one sub-module, jtdd_mcu_arb_tmr (load, cen, zero/expire outputs).

Verification
REQ-034 main_req=1, mcu_halted rises 5 clk later -> main_ack=1 one cycle after; main_req=0 -> main_ack=0 and mcu_halt=0 on the next edge.
REQ-035 main_req=1, mcu_halted held 0, TOUT=8 -> tout_err=1 after 8 cen6 ticks, main_ack stays 0, FSM returns to IDLE.
REQ-036 nmi_req pulsed twice during GRANT -> exactly one mcu_nmi_set pulse, after mcu_halted falls.
REQ-037 nmi_req and main_req on the same cycle in IDLE -> NMI pulse first, then HALT once the GAP counter reaches 0.
REQ-038 Back-to-back main_req, GAP=4 -> mcu_halt stays low for at least 4 cen6 ticks between the two grants.
REQ-039 rstb=0 during GRANT -> main_ack, mcu_halt and busy are 0 without waiting for a clk edge; with JTDD_MCUARB_STATS_EN defined, grant_cnt=0.

Source files
------------

// File: rtl/jtdd_mcu_pkg.sv
// Shared definitions for the main-CPU / MCU shared-RAM arbiter.
// State encoding, default timing constants and the timer control bundle.
package jtdd_mcu_pkg;

  localparam logic [7:0] TOUT_DEF = 8'd200;
  localparam logic [2:0] GAP_DEF  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    GRANT = 3'd2,
    REL   = 3'd3,
    NMI   = 3'd4
  } state_t;

  // FSM -> timer control: run the halt timeout, load the inter-halt gap
  typedef struct packed {
    logic tout_run;
    logic gap_load;
  } tmr_ctl_t;

endpackage

// File: rtl/jtdd_mcu_arb_tmr.sv
// Timeout and gap counters for the MCU arbiter.
// The timeout counter runs only while tout_run is high and sits at zero otherwise,
// so every entry into HALT starts from zero. It saturates instead of wrapping.
// The gap counter loads GAP on request (independent of cen) and drains to zero.
module jtdd_mcu_arb_tmr
  import jtdd_mcu_pkg::*;
#(
  parameter logic [7:0] TOUT = TOUT_DEF,
  parameter logic [2:0] GAP  = GAP_DEF
) (
  input  logic     clk,
  input  logic     rstb,
  input  logic     cen,
  input  tmr_ctl_t ctl,
  output logic     tout_exp,
  output logic     gap_zero
);

  logic [7:0] tmo_q;
  logic [2:0] gap_q;

  // timeout count while halting, gap countdown after a release
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tmo_q <= 8'd0;
      gap_q <= 3'd0;
    end else begin
      if (!ctl.tout_run)
        tmo_q <= 8'd0;
      else if (cen && tmo_q != 8'hFF)
        tmo_q <= tmo_q + 8'd1;
      if (ctl.gap_load)
        gap_q <= GAP;
      else if (cen && gap_q != 3'd0)
        gap_q <= gap_q - 3'd1;
    end
  end

  assign tout_exp = (tmo_q >= TOUT);
  assign gap_zero = (gap_q == 3'd0);

endmodule

// File: rtl/jtdd_mcu_arb.sv
// Shared-RAM arbiter between the main CPU and the MCU.
// Halts the MCU on a main CPU request, grants the RAM once the MCU acknowledges,
// enforces a minimum run gap between halts and forwards one-deep buffered NMIs.
// Optional build macro JTDD_MCUARB_STATS_EN adds saturating grant/timeout counters.
module jtdd_mcu_arb
  import jtdd_mcu_pkg::*;
#(
  parameter logic [7:0] TOUT = TOUT_DEF,
  parameter logic [2:0] GAP  = GAP_DEF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        cen6,
  input  logic        main_req,
  input  logic        nmi_req,
  output logic        main_ack,
  output logic        mcu_halt,
  input  logic        mcu_halted,
  output logic        mcu_nmi_set,
  output logic        busy,
`ifdef JTDD_MCUARB_STATS_EN
  output logic [15:0] grant_cnt,
  output logic [7:0]  tout_cnt,
`endif
  output logic        tout_err
);

  state_t   state;
  logic     ack_q;
  logic     nmi_pend;
  logic     nmi_any;
  logic     tout_exp;
  logic     gap_zero;
  tmr_ctl_t tmr_ctl;

  // a request arriving this cycle counts as pending, so it can win over main_req
  assign nmi_any = nmi_pend | nmi_req;

  assign tmr_ctl.tout_run = (state == HALT);
  assign tmr_ctl.gap_load = (state == REL) && !mcu_halted;

  jtdd_mcu_arb_tmr #(.TOUT(TOUT), .GAP(GAP)) u_tmr (
    .clk      (clk),
    .rstb     (rstb),
    .cen      (cen6),
    .ctl      (tmr_ctl),
    .tout_exp (tout_exp),
    .gap_zero (gap_zero)
  );

  // arbitration FSM with registered handshake outputs and the NMI pending flag
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      ack_q       <= 1'b0;
      mcu_halt    <= 1'b0;
      mcu_nmi_set <= 1'b0;
      tout_err    <= 1'b0;
      nmi_pend    <= 1'b0;
    end else begin
      mcu_nmi_set <= 1'b0;
      if (nmi_req) nmi_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (nmi_any) begin
            // consume one request; a second one on this edge stays pending
            state       <= NMI;
            mcu_nmi_set <= 1'b1;
            nmi_pend    <= nmi_pend & nmi_req;
          end else if (main_req && gap_zero) begin
            state    <= HALT;
            mcu_halt <= 1'b1;
          end
        end
        HALT: begin
          if (mcu_halted) begin
            state <= GRANT;
            ack_q <= 1'b1;
          end else if (tout_exp) begin
            state    <= REL;
            mcu_halt <= 1'b0;
            tout_err <= 1'b1;
          end
        end
        GRANT: begin
          if (!main_req) begin
            state    <= REL;
            ack_q    <= 1'b0;
            mcu_halt <= 1'b0;
          end
        end
        REL: begin
          if (!mcu_halted) begin
            if (nmi_any) begin
              state       <= NMI;
              mcu_nmi_set <= 1'b1;
              nmi_pend    <= nmi_pend & nmi_req;
            end else begin
              state <= IDLE;
            end
          end
        end
        NMI:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // never present a grant the MCU is not currently acknowledging
  assign main_ack = ack_q & mcu_halted;
  assign busy     = (state != IDLE);

`ifdef JTDD_MCUARB_STATS_EN
  // saturating event counters for grants and halt timeouts
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grant_cnt <= 16'd0;
      tout_cnt  <= 8'd0;
    end else if (state == HALT) begin
      if (mcu_halted) begin
        if (grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
      end else if (tout_exp) begin
        if (tout_cnt != 8'hFF) tout_cnt <= tout_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jtdd_mcu_arb.sv
// Directed bench for jtdd_mcu_arb: a per-cycle vector table for NMI buffering,
// grant handshake and gap spacing, then hand sequences for timeout, cen6 gating
// and asynchronous reset during a grant.
module tb_jtdd_mcu_arb;

  logic clk = 1'b0, rstb = 1'b0, cen6 = 1'b1;
  logic main_req = 1'b0, nmi_req = 1'b0, mcu_halted = 1'b0;
  logic main_ack, mcu_halt, mcu_nmi_set, busy, tout_err;
`ifdef JTDD_MCUARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [7:0]  tout_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtdd_mcu_arb #(.TOUT(8'd8), .GAP(3'd4)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cen6        (cen6),
    .main_req    (main_req),
    .nmi_req     (nmi_req),
    .main_ack    (main_ack),
    .mcu_halt    (mcu_halt),
    .mcu_halted  (mcu_halted),
    .mcu_nmi_set (mcu_nmi_set),
    .busy        (busy),
`ifdef JTDD_MCUARB_STATS_EN
    .grant_cnt   (grant_cnt),
    .tout_cnt    (tout_cnt),
`endif
    .tout_err    (tout_err)
  );

  // {inputs mr,nr,h} -> {expected ack,halt,nmi,busy,terr} one clk later
  typedef struct packed {
    logic mr, nr, h;
    logic ack, halt, nmi, bsy, terr;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ack_seen;

    //               mr nr h  ack halt nmi bsy terr
    tbl[0]  = vec_t'(8'b0_1_0__0_0_1_1_0); // nmi straight from IDLE
    tbl[1]  = vec_t'(8'b0_1_0__0_0_0_0_0); // pulse in NMI gets buffered
    tbl[2]  = vec_t'(8'b0_1_0__0_0_1_1_0); // pending consumed, new pulse re-sets it
    tbl[3]  = vec_t'(8'b0_0_0__0_0_0_0_0);
    tbl[4]  = vec_t'(8'b0_0_0__0_0_1_1_0); // buffered pulse delivered
    tbl[5]  = vec_t'(8'b0_0_0__0_0_0_0_0);
    tbl[6]  = vec_t'(8'b0_0_0__0_0_0_0_0); // nothing left over
    tbl[7]  = vec_t'(8'b1_1_0__0_0_1_1_0); // nmi beats main_req
    tbl[8]  = vec_t'(8'b1_0_0__0_0_0_0_0);
    tbl[9]  = vec_t'(8'b1_0_0__0_1_0_1_0); // halt after the NMI
    tbl[10] = vec_t'(8'b1_0_0__0_1_0_1_0);
    tbl[11] = vec_t'(8'b1_0_1__1_1_0_1_0); // grant
    tbl[12] = vec_t'(8'b1_1_1__1_1_0_1_0); // two nmi pulses during grant
    tbl[13] = vec_t'(8'b1_1_1__1_1_0_1_0);
    tbl[14] = vec_t'(8'b0_0_1__0_0_0_1_0); // release: ack and halt drop
    tbl[15] = vec_t'(8'b0_0_1__0_0_0_1_0); // wait for halted to fall
    tbl[16] = vec_t'(8'b0_0_0__0_0_1_1_0); // single NMI after halted falls
    tbl[17] = vec_t'(8'b0_0_1__0_0_0_0_0); // halted ignored in IDLE
    tbl[18] = vec_t'(8'b0_0_1__0_0_0_0_0);
    tbl[19] = vec_t'(8'b1_0_0__0_0_0_0_0); // gap still running
    tbl[20] = vec_t'(8'b1_0_0__0_0_0_0_0);
    tbl[21] = vec_t'(8'b1_0_0__0_1_0_1_0); // gap expired -> halt
    tbl[22] = vec_t'(8'b1_0_1__1_1_0_1_0);
    tbl[23] = vec_t'(8'b0_0_1__0_0_0_1_0);
    tbl[24] = vec_t'(8'b0_0_0__0_0_0_0_0); // back to IDLE, gap reloaded

    // reset state
    #1;
    chk1("rst.ack",  main_ack,    1'b0);
    chk1("rst.halt", mcu_halt,    1'b0);
    chk1("rst.nmi",  mcu_nmi_set, 1'b0);
    chk1("rst.busy", busy,        1'b0);
    chk1("rst.terr", tout_err,    1'b0);
`ifdef JTDD_MCUARB_STATS_EN
    chk16("rst.gcnt", grant_cnt, 16'd0);
    chk16("rst.tcnt", 16'(tout_cnt), 16'd0);
`endif
    step();
    rstb = 1'b1;

    for (int i = 0; i < NV; i++) begin
      main_req   = tbl[i].mr;
      nmi_req    = tbl[i].nr;
      mcu_halted = tbl[i].h;
      step();
      chk1($sformatf("v%0d.ack", i),  main_ack,    tbl[i].ack);
      chk1($sformatf("v%0d.halt", i), mcu_halt,    tbl[i].halt);
      chk1($sformatf("v%0d.nmi", i),  mcu_nmi_set, tbl[i].nmi);
      chk1($sformatf("v%0d.busy", i), busy,        tbl[i].bsy);
      chk1($sformatf("v%0d.terr", i), tout_err,    tbl[i].terr);
    end
    nmi_req = 1'b0;

    // halt timeout: gap of 4 drains first, then 8 ticks plus the exit edge
    main_req   = 1'b1;
    mcu_halted = 1'b0;
    n = 0;
    while (!mcu_halt && n < 20) begin step(); n++; end
    chk16("tmo.gap_wait", 16'(n), 16'd5);
    n = 0;
    ack_seen = 1'b0;
    while (!tout_err && n < 40) begin
      step();
      n++;
      if (main_ack) ack_seen = 1'b1;
    end
    chk16("tmo.cycles", 16'(n), 16'd9);
    chk1("tmo.no_ack", ack_seen, 1'b0);
    chk1("tmo.halt",   mcu_halt, 1'b0);

    // cen6 low freezes the freshly loaded gap: no halt however long we wait
    cen6 = 1'b0;
    repeat (10) step();
    chk1("cen.halt", mcu_halt, 1'b0);
    chk1("cen.busy", busy,     1'b0);
    chk1("cen.terr", tout_err, 1'b1);
    cen6 = 1'b1;
    n = 0;
    while (!mcu_halt && n < 20) begin step(); n++; end
    chk16("cen.gap_wait", 16'(n), 16'd5);
    mcu_halted = 1'b1;
    step();
    chk1("g3.ack", main_ack, 1'b1);
`ifdef JTDD_MCUARB_STATS_EN
    chk16("st.gcnt", grant_cnt, 16'd3);
    chk16("st.tcnt", 16'(tout_cnt), 16'd1);
`endif

    // leave an NMI pending, then reset mid-grant between clock edges
    nmi_req = 1'b1;
    step();
    nmi_req = 1'b0;
    #2 rstb = 1'b0;
    #1;
    chk1("arst.ack",  main_ack, 1'b0);
    chk1("arst.halt", mcu_halt, 1'b0);
    chk1("arst.busy", busy,     1'b0);
    chk1("arst.terr", tout_err, 1'b0);
`ifdef JTDD_MCUARB_STATS_EN
    chk16("arst.gcnt", grant_cnt, 16'd0);
`endif
    step();
    rstb       = 1'b1;
    main_req   = 1'b0;
    mcu_halted = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("post%0d.nmi", i),  mcu_nmi_set, 1'b0);
      chk1($sformatf("post%0d.busy", i), busy,        1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
